// File: rtl/swd_pkg.sv
// Shared SWD target definitions: monitor states, the line-reset length and
// the positions of the request-header bits (start bit = 0 ... park bit = 7).
package swd_pkg;

    typedef enum logic [2:0] {
        UNSYNC,
        LRST,
        IDLE,
        HDR,
        BUSY
    } swd_state_e;

    localparam int SWD_LINE_RESET_MIN = 50;

    localparam int HDR_START = 0;
    localparam int HDR_APNDP = 1;
    localparam int HDR_RNW   = 2;
    localparam int HDR_A2    = 3;
    localparam int HDR_A3    = 4;
    localparam int HDR_PAR   = 5;
    localparam int HDR_STOP  = 6;
    localparam int HDR_PARK  = 7;

endpackage

// File: rtl/swd_run_counter.sv
// Saturating run-length counter: counts consecutive enabled samples equal to
// 'level' and flags the sample on which the run first reaches THRESH.
module swd_run_counter #(
    parameter int THRESH = 50,
    parameter int W      = $clog2(THRESH + 1)
) (
    input  logic         sck,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    input  logic         level,
    output logic [W-1:0] count,
    output logic         reached
);

    // Fires only on the THRESH-1 -> THRESH step, so a saturated run never re-fires.
    assign reached = en && (din == level) && (count == W'(THRESH - 1));

    // NOTE: sequential state is written with non-blocking assignments only;
    // blocking ones here would race against every other clocked reader.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (din != level) begin
                count <= '0;
            end else if (count != W'(THRESH)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/swd_target_seq_monitor.sv
// Target-side SWD sequence monitor: line-reset detection, idle-zero counting
// and request-header parsing on the sampled SWDIO stream.
module swd_target_seq_monitor
    import swd_pkg::*;
#(
    parameter int RESET_LEN = SWD_LINE_RESET_MIN,
    parameter int IDLE_W    = 8
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              swdio_in,
    input  logic              hdr_done,
    output logic              line_reset,
    output logic              synced,
    output logic [IDLE_W-1:0] idle_cnt,
    output logic              hdr_valid,
    output logic              hdr_err,
    output logic              hdr_apndp,
    output logic              hdr_rnw,
    output logic [1:0]        hdr_addr
);

    localparam int RUN_W = $clog2(RESET_LEN + 1);

    swd_state_e        state, state_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [5:0]        hdr_sr, hdr_sr_n;
    logic [IDLE_W-1:0] idle_n;
    logic              synced_n, hdr_valid_n, hdr_err_n, hdr_apndp_n, hdr_rnw_n;
    logic [1:0]        hdr_addr_n;
    logic              hdr_bad;
    logic [RUN_W-1:0]  ones_cnt;
    logic              ones_reached;
    logic              unused_ones_cnt;

    swd_run_counter #(
        .THRESH(RESET_LEN),
        .W     (RUN_W)
    ) u_ones_run (
        .sck    (sck),
        .rst    (rst),
        .en     (sample_en),
        .din    (swdio_in),
        .level  (1'b1),
        .count  (ones_cnt),
        .reached(ones_reached)
    );

    // Only the threshold pulse matters here; the run length itself is not consumed.
    assign unused_ones_cnt = ^ones_cnt;

    // Header bits 1..6 are shifted in LSB first, so bit i sits at hdr_sr[i-1] once park arrives.
    always_comb begin
        // NOTE: every variable of this block gets a default first, so no path infers a latch.
        state_n     = state;
        bit_idx_n   = bit_idx;
        hdr_sr_n    = hdr_sr;
        idle_n      = idle_cnt;
        synced_n    = synced;
        hdr_valid_n = 1'b0;
        hdr_err_n   = hdr_err;
        hdr_apndp_n = hdr_apndp;
        hdr_rnw_n   = hdr_rnw;
        hdr_addr_n  = hdr_addr;
        hdr_bad     = (hdr_sr[HDR_PAR-1] != ^hdr_sr[HDR_A3-1:HDR_APNDP-1])
                    | hdr_sr[HDR_STOP-1] | ~swdio_in;

        if (ones_reached) begin
            state_n   = LRST;
            synced_n  = 1'b1;
            idle_n    = '0;
            bit_idx_n = '0;
            hdr_sr_n  = '0;
        end else begin
            case (state)
                UNSYNC: ;
                LRST: begin
                    if (sample_en && !swdio_in) begin
                        state_n = IDLE;
                        idle_n  = IDLE_W'(1);
                    end
                end
                IDLE: begin
                    if (sample_en) begin
                        if (swdio_in) begin
                            state_n   = HDR;
                            bit_idx_n = 3'(HDR_APNDP);
                        end else if (idle_cnt != {IDLE_W{1'b1}}) begin
                            idle_n = idle_cnt + 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (sample_en) begin
                        if (bit_idx == 3'(HDR_PARK)) begin
                            hdr_valid_n = 1'b1;
                            hdr_err_n   = hdr_bad;
                            hdr_apndp_n = hdr_sr[HDR_APNDP-1];
                            hdr_rnw_n   = hdr_sr[HDR_RNW-1];
                            hdr_addr_n  = {hdr_sr[HDR_A3-1], hdr_sr[HDR_A2-1]};
                            bit_idx_n   = '0;
                            hdr_sr_n    = '0;
                            state_n     = hdr_bad ? UNSYNC : BUSY;
                            synced_n    = ~hdr_bad;
                        end else begin
                            hdr_sr_n  = {swdio_in, hdr_sr[5:1]};
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (hdr_done) begin
                        state_n = IDLE;
                        idle_n  = '0;
                    end
                end
                default: state_n = UNSYNC;
            endcase
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state      <= UNSYNC;
            bit_idx    <= '0;
            hdr_sr     <= '0;
            idle_cnt   <= '0;
            synced     <= 1'b0;
            line_reset <= 1'b0;
            hdr_valid  <= 1'b0;
            hdr_err    <= 1'b0;
            hdr_apndp  <= 1'b0;
            hdr_rnw    <= 1'b0;
            hdr_addr   <= '0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            hdr_sr     <= hdr_sr_n;
            idle_cnt   <= idle_n;
            synced     <= synced_n;
            line_reset <= ones_reached;
            hdr_valid  <= hdr_valid_n;
            hdr_err    <= hdr_err_n;
            hdr_apndp  <= hdr_apndp_n;
            hdr_rnw    <= hdr_rnw_n;
            hdr_addr   <= hdr_addr_n;
        end
    end

endmodule

// File: tb/tb_swd_target_seq_monitor.sv
// Scoreboard bench for swd_target_seq_monitor: directed scenarios plus random
// SWDIO traffic checked against a queue-based reference model.
module tb_swd_target_seq_monitor;

    localparam int RESET_LEN = 50;
    localparam int IDLE_W    = 8;
    localparam int IDLE_MAX  = (1 << IDLE_W) - 1;

    localparam int PH_LOST  = 0;
    localparam int PH_RESET = 1;
    localparam int PH_IDLE  = 2;
    localparam int PH_HDR   = 3;
    localparam int PH_BUSY  = 4;

    logic              sck = 1'b0;
    logic              rst;
    logic              sample_en, swdio_in, hdr_done;
    logic              line_reset, synced, hdr_valid, hdr_err, hdr_apndp, hdr_rnw;
    logic [IDLE_W-1:0] idle_cnt;
    logic [1:0]        hdr_addr;

    swd_target_seq_monitor #(
        .RESET_LEN(RESET_LEN),
        .IDLE_W   (IDLE_W)
    ) dut (
        .sck       (sck),
        .rst       (rst),
        .sample_en (sample_en),
        .swdio_in  (swdio_in),
        .hdr_done  (hdr_done),
        .line_reset(line_reset),
        .synced    (synced),
        .idle_cnt  (idle_cnt),
        .hdr_valid (hdr_valid),
        .hdr_err   (hdr_err),
        .hdr_apndp (hdr_apndp),
        .hdr_rnw   (hdr_rnw),
        .hdr_addr  (hdr_addr)
    );

    always #5 sck = ~sck;

    typedef struct {
        int cyc;
        bit is_hdr;
        bit err;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    // Reference model: ones run, protocol phase, idle count and collected header bits.
    int  m_ones, m_phase, m_idle, m_addr;
    bit  m_synced, m_ap, m_rnw, m_err;
    bit  hq[$];

    always @(posedge sck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ones = 0; m_phase = PH_LOST; m_idle = 0; m_synced = 0;
        m_ap = 0; m_rnw = 0; m_addr = 0; m_err = 0;
        hq.delete();
    endtask

    task automatic model_step(input bit s, input bit b, input bit d);
        bit  lr;
        bit  bad;
        int  field_ones;
        ev_t e;
        lr = 0;
        if (s) begin
            if (!b) m_ones = 0;
            else if (m_ones < RESET_LEN) begin
                m_ones++;
                lr = (m_ones == RESET_LEN);
            end
        end
        if (lr) begin
            m_phase = PH_RESET; m_synced = 1; m_idle = 0; hq.delete();
            e.cyc = cyc; e.is_hdr = 0; e.err = 0;
            exp_q.push_back(e);
            return;
        end
        case (m_phase)
            PH_RESET: if (s && !b) begin m_phase = PH_IDLE; m_idle = 1; end
            PH_IDLE: if (s) begin
                if (b) begin m_phase = PH_HDR; hq.delete(); end
                else if (m_idle < IDLE_MAX) m_idle++;
            end
            PH_HDR: if (s) begin
                hq.push_back(b);
                if (hq.size() == 7) begin
                    field_ones = int'(hq[0]) + int'(hq[1]) + int'(hq[2]) + int'(hq[3]);
                    bad = ((field_ones % 2) != int'(hq[4])) || hq[5] || !hq[6];
                    m_ap = hq[0]; m_rnw = hq[1]; m_addr = 2 * int'(hq[3]) + int'(hq[2]);
                    m_err = bad;
                    e.cyc = cyc; e.is_hdr = 1; e.err = bad;
                    exp_q.push_back(e);
                    m_phase  = bad ? PH_LOST : PH_BUSY;
                    m_synced = !bad;
                    hq.delete();
                end
            end
            PH_BUSY: if (d) begin m_phase = PH_IDLE; m_idle = 0; end
            default: ;
        endcase
    endtask

    // Monitor: pops an expected event whenever the DUT pulses, and tracks the level outputs.
    always @(negedge sck) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("event_missed_at_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (line_reset || hdr_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, line_reset, hdr_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_hdr_valid", hdr_valid, e.is_hdr);
                check("event_line_reset", line_reset, !e.is_hdr);
                if (e.is_hdr) check("hdr_err", hdr_err, e.err);
            end
        end
        check("synced", synced, m_synced);
        check("idle_cnt", idle_cnt, m_idle);
        check("hdr_apndp", hdr_apndp, m_ap);
        check("hdr_rnw", hdr_rnw, m_rnw);
        check("hdr_addr", hdr_addr, m_addr);
    end

    task automatic apply(input bit s, input bit b, input bit d);
        sample_en = s; swdio_in = b; hdr_done = d;
        @(posedge sck);
        #1;
        model_step(s, b, d);
        sample_en = 0; swdio_in = 0; hdr_done = 0;
    endtask

    task automatic send_run(input bit b, input int n);
        for (int i = 0; i < n; i++) apply(1'b1, b, 1'b0);
    endtask

    task automatic send_byte(input bit [7:0] v, input bit gapped);
        for (int i = 0; i < 8; i++) begin
            if (gapped) apply(1'b0, 1'($urandom), 1'b0);
            apply(1'b1, v[i], 1'b0);
        end
    endtask

    task automatic hdr_byte(input bit ap, input bit rnw, input bit [1:0] addr,
                            input bit flip_par, output bit [7:0] h);
        h = {1'b1, 1'b0, ap ^ rnw ^ addr[0] ^ addr[1] ^ flip_par, addr[1], addr[0], rnw, ap, 1'b1};
    endtask

    task automatic line_reset_seq();
        send_run(1'b0, 1);
        send_run(1'b1, RESET_LEN);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_line_reset"}, line_reset, 0);
        check({tag, "_synced"}, synced, 0);
        check({tag, "_idle_cnt"}, idle_cnt, 0);
        check({tag, "_hdr_valid"}, hdr_valid, 0);
        check({tag, "_hdr_err"}, hdr_err, 0);
        check({tag, "_hdr_apndp"}, hdr_apndp, 0);
        check({tag, "_hdr_rnw"}, hdr_rnw, 0);
        check({tag, "_hdr_addr"}, hdr_addr, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] h;
        int       n;
        rst = 1'b1; sample_en = 0; swdio_in = 0; hdr_done = 0;
        model_reset();
        repeat (3) @(posedge sck);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: line reset at the 50th one, then 50 idle zeros
        send_run(1'b1, 64);
        send_run(1'b0, 50);
        check("t1_synced", synced, 1);
        check("t1_idle_cnt", idle_cnt, 50);

        // 2: good DP read header 0xA5; zeros afterwards are ignored in BUSY
        line_reset_seq();
        send_run(1'b0, 2);
        send_byte(8'hA5, 1'b0);
        check("t2_apndp", hdr_apndp, 0);
        check("t2_rnw", hdr_rnw, 1);
        check("t2_addr", hdr_addr, 0);
        check("t2_synced", synced, 1);
        send_run(1'b0, 3);
        check("t2_busy_idle_hold", idle_cnt, 2);

        // 5: 50th one of a BUSY run coincides with hdr_done -> line reset wins
        send_run(1'b0, 1);
        send_run(1'b1, RESET_LEN - 1);
        apply(1'b1, 1'b1, 1'b1);
        check("t5_synced", synced, 1);
        send_run(1'b1, 1);
        send_run(1'b0, 3);
        check("t5_lrst_idle", idle_cnt, 3);

        // 3: parity error -> unsynced, idle count frozen
        line_reset_seq();
        send_run(1'b0, 2);
        send_byte(8'h85, 1'b0);
        check("t3_synced", synced, 0);
        send_run(1'b0, 5);
        check("t3_idle_frozen", idle_cnt, 2);

        // 4: 40 ones in BUSY, hdr_done; then 49 ones cannot line-reset
        line_reset_seq();
        send_run(1'b0, 2);
        send_byte(8'hA5, 1'b0);
        send_run(1'b1, 40);
        apply(1'b1, 1'b0, 1'b1);
        check("t4_idle_after_done", idle_cnt, 0);
        send_run(1'b1, RESET_LEN - 1);
        send_run(1'b0, 1);

        // 6: reset mid-header
        line_reset_seq();
        send_run(1'b0, 2);
        for (int i = 0; i < 4; i++) apply(1'b1, h[i] | (i == 0) | (i == 2), 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs_zero("t6_rst");
        repeat (2) @(posedge sck);
        #1;
        rst = 1'b0;
        send_run(1'b0, 1);
        send_run(1'b1, 1);
        send_run(1'b0, 1);
        send_run(1'b1, 1);
        send_run(1'b0, 4);
        check("t6_synced", synced, 0);

        // 7: scenario 2 with sample_en gaps; unsampled zeros are not counted
        send_run(1'b0, 1);
        for (int i = 0; i < RESET_LEN; i++) begin
            apply(1'b0, 1'b0, 1'b0);
            apply(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0);
            apply(1'b1, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0);
        check("t7_idle_cnt", idle_cnt, 2);
        send_byte(8'hA5, 1'b1);
        check("t7_apndp", hdr_apndp, 0);
        check("t7_rnw", hdr_rnw, 1);
        check("t7_addr", hdr_addr, 0);
        check("t7_synced", synced, 1);
        apply(1'b0, 1'b0, 1'b1);

        // Idle counter saturation
        send_run(1'b0, 260);
        check("sat_idle_cnt", idle_cnt, IDLE_MAX);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 8))
                0: begin
                    n = RESET_LEN + $urandom_range(0, 8);
                    for (int k = 0; k < n; k++) apply(1'b1, 1'b1, ($urandom_range(0, 15) == 0));
                end
                1, 2, 3: begin
                    hdr_byte(1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 5) == 0), h);
                    send_byte(h, 1'($urandom));
                end
                4: send_byte(8'($urandom), 1'($urandom));
                5, 6: begin
                    n = $urandom_range(1, 20);
                    for (int k = 0; k < n; k++) apply(1'($urandom), 1'b0, 1'b0);
                end
                7: apply(1'($urandom), 1'($urandom), 1'b1);
                default: begin
                    n = $urandom_range(1, 10);
                    for (int k = 0; k < n; k++)
                        apply(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
                end
            endcase
        end

        repeat (5) @(posedge sck);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
